mem_access_stage: RTL and testbench

Memory-access pipeline stage between execute and register-file writeback. Takes one execute-stage result per handshake, either passes an ALU result straight to the writeback port or performs a RISC-V load/store byte-serially over an 8-bit memory port. Load data is sign- or zero-extended before writeback. Its writeback outputs drive the register file's write port (`write_enable` / `write_addr` / `write_data`) directly.

---
 rtl/mem_access_stage_if.sv | 34 +++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - execute, memory and writeback signals of the memory-access stage
interface mem_access_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [31:0] ex_alu_result;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_gnt;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    // The stage itself
    modport slave (
        input  ex_valid, ex_mem_op, ex_addr, ex_store_data, ex_alu_result, ex_rd, ex_wb_en,
        input  mem_din, mem_gnt,
        output ex_ready, mem_req, mem_wr, mem_addr, mem_dout, wb_en, wb_addr, wb_data
    );

    // Execute stage, memory and register file around it
    modport master (
        output ex_valid, ex_mem_op, ex_addr, ex_store_data, ex_alu_result, ex_rd, ex_wb_en,
        output mem_din, mem_gnt,
        input  ex_ready, mem_req, mem_wr, mem_addr, mem_dout, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage: ALU pass-through or byte-serial RISC-V load/store
module mem_access_stage (
    input  logic              clk,
    input  logic              rst,
    mem_access_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_LAST} state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [4:0]  rd_q;
    logic        wben_q;
    logic [2:0]  k_q;
    logic [31:0] buf_q;
    logic        pend_q;
    logic [1:0]  pend_idx_q;
    logic        mem_req_q;
    logic        mem_wr_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  mem_dout_q;
    logic        wb_en_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;

    logic [2:0]  k_d;
    logic        last_d;
    logic [31:0] load_word_d;
    logic [31:0] ext_d;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic [2:0] byte_cnt(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 3'd1;
            4'd2, 4'd5, 4'd7: return 3'd2;
            default:          return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    // The byte granted last cycle is merged in here so WAIT_LAST can write back without an extra cycle
    always_comb begin
        k_d         = k_q + 3'd1;
        last_d      = (k_d == byte_cnt(op_q));
        load_word_d = buf_q;
        if (pend_q) begin
            load_word_d[{pend_idx_q, 3'b000} +: 8] = bus.mem_din;
        end
        case (op_q)
            4'd1:    ext_d = {{24{load_word_d[7]}}, load_word_d[7:0]};
            4'd2:    ext_d = {{16{load_word_d[15]}}, load_word_d[15:0]};
            4'd4:    ext_d = {24'b0, load_word_d[7:0]};
            4'd5:    ext_d = {16'b0, load_word_d[15:0]};
            default: ext_d = load_word_d;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            wben_q     <= 1'b0;
            k_q        <= '0;
            buf_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            mem_req_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_en_q <= 1'b0;
            pend_q  <= 1'b0;
            if (pend_q) begin
                buf_q <= load_word_d;
            end
            case (state_q)
                IDLE: begin
                    if (bus.ex_valid) begin
                        op_q    <= bus.ex_mem_op;
                        addr_q  <= bus.ex_addr;
                        sdata_q <= bus.ex_store_data;
                        rd_q    <= bus.ex_rd;
                        wben_q  <= bus.ex_wb_en;
                        if (is_mem(bus.ex_mem_op)) begin
                            state_q    <= ACCESS;
                            k_q        <= '0;
                            mem_req_q  <= 1'b1;
                            mem_wr_q   <= is_store(bus.ex_mem_op);
                            mem_addr_q <= bus.ex_addr;
                            mem_dout_q <= bus.ex_store_data[7:0];
                        end else begin
                            wb_en_q   <= bus.ex_wb_en;
                            wb_addr_q <= bus.ex_rd;
                            wb_data_q <= bus.ex_alu_result;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_gnt) begin
                        k_q        <= k_d;
                        pend_q     <= ~mem_wr_q;
                        pend_idx_q <= k_q[1:0];
                        if (last_d) begin
                            mem_req_q <= 1'b0;
                            mem_wr_q  <= 1'b0;
                            state_q   <= mem_wr_q ? IDLE : WAIT_LAST;
                        end else begin
                            mem_addr_q <= addr_q + {29'b0, k_d};
                            mem_dout_q <= byte_sel(sdata_q, k_d[1:0]);
                        end
                    end
                end
                WAIT_LAST: begin
                    wb_en_q   <= wben_q;
                    wb_addr_q <= rd_q;
                    wb_data_q <= ext_d;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ex_ready = (state_q == IDLE) && !rst;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.wb_en    = wb_en_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and randomized checks of mem_access_stage against a byte-level model
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_stage_if bus();
    mem_access_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] phys [logic [31:0]];
    logic [7:0] mdl  [logic [31:0]];

    logic        m_busy, m_wait, m_store, m_we;
    int          m_k, m_n;
    logic [31:0] m_addr, m_sdata, m_ldval;
    logic [4:0]  m_rd;
    logic        e_req, e_wr, e_wben;
    logic [31:0] e_addr, e_wbdata;
    logic [7:0]  e_dout;
    logic [4:0]  e_wbaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C ^ {a[2:0], a[7:3]};
    endfunction

    function automatic logic [7:0] rd_phys(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rd_mdl(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : init_byte(a);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        phys[a] = d;
        mdl[a]  = d;
    endtask

    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] a, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(rd_mdl(a + 32'(i))) << (8 * i));
        if (op == 4'd1 && v[7])  v = v | 32'hFFFFFF00;
        if (op == 4'd2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_wait = 1'b0; m_store = 1'b0; m_we = 1'b0;
        m_k = 0; m_n = 0; m_addr = '0; m_sdata = '0; m_ldval = '0; m_rd = '0;
        e_req = 1'b0; e_wr = 1'b0; e_wben = 1'b0; e_addr = '0; e_dout = '0;
        e_wbaddr = '0; e_wbdata = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied
    task automatic model_advance();
        logic [3:0] op;
        if (rst) begin
            model_reset();
            return;
        end
        e_wben = 1'b0;
        op = bus.ex_mem_op;
        if (!m_busy) begin
            if (bus.ex_valid) begin
                if (op >= 4'd1 && op <= 4'd8) begin
                    m_busy = 1'b1; m_wait = 1'b0; m_k = 0;
                    m_addr = bus.ex_addr; m_sdata = bus.ex_store_data;
                    m_rd = bus.ex_rd; m_we = bus.ex_wb_en;
                    m_store = (op >= 4'd6);
                    m_n = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
                          (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
                    if (!m_store) m_ldval = load_value(op, bus.ex_addr, m_n);
                end else begin
                    e_wben = bus.ex_wb_en; e_wbaddr = bus.ex_rd; e_wbdata = bus.ex_alu_result;
                end
            end
        end else if (m_wait) begin
            e_wben = m_we; e_wbaddr = m_rd; e_wbdata = m_ldval;
            m_busy = 1'b0; m_wait = 1'b0;
        end else if (bus.mem_gnt) begin
            if (m_store) mdl[m_addr + 32'(m_k)] = 8'(m_sdata >> (8 * m_k));
            m_k++;
            if (m_k == m_n) begin
                if (m_store) m_busy = 1'b0;
                else m_wait = 1'b1;
            end
        end
        if (m_busy && !m_wait) begin
            e_req = 1'b1; e_wr = m_store;
            e_addr = m_addr + 32'(m_k);
            e_dout = 8'(m_sdata >> (8 * m_k));
        end else begin
            e_req = 1'b0; e_wr = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("ex_ready", 32'(bus.ex_ready), 32'(!m_busy && !rst));
        chk("mem_req",  32'(bus.mem_req),  32'(e_req));
        chk("mem_wr",   32'(bus.mem_wr),   32'(e_wr));
        chk("mem_addr", bus.mem_addr,      e_addr);
        chk("mem_dout", 32'(bus.mem_dout), 32'(e_dout));
        chk("wb_en",    32'(bus.wb_en),    32'(e_wben));
        chk("wb_addr",  32'(bus.wb_addr),  32'(e_wbaddr));
        chk("wb_data",  bus.wb_data,       e_wbdata);
    endtask

    // One clock: memory responds to the DUT, model steps, then outputs are compared at the falling edge
    task automatic tick();
        logic        pend;
        logic [31:0] pa;
        pend = 1'b0;
        pa   = '0;
        if (!rst && bus.mem_req && bus.mem_gnt) begin
            if (bus.mem_wr) phys[bus.mem_addr] = bus.mem_dout;
            else begin pend = 1'b1; pa = bus.mem_addr; end
        end
        model_advance();
        @(negedge clk);
        bus.mem_din = pend ? rd_phys(pa) : 8'($urandom);
        compare_all();
    endtask

    task automatic set_ex(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] alu, input logic [4:0] rd,
                          input logic we);
        bus.ex_valid = v; bus.ex_mem_op = op; bus.ex_addr = a; bus.ex_store_data = sd;
        bus.ex_alu_result = alu; bus.ex_rd = rd; bus.ex_wb_en = we;
    endtask

    task automatic do_load(input logic [3:0] op, input logic [31:0] a,
                           output logic [31:0] res, output int lat);
        bit seen;
        seen = 0; res = '0; lat = 0;
        set_ex(1'b1, op, a, 32'h0, 32'h0, 5'd1, 1'b1);
        bus.mem_gnt = 1'b1;
        tick();
        bus.ex_valid = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (bus.wb_en) begin seen = 1; res = bus.wb_data; lat = c; end
            else tick();
        end
        chk("load_completes", 32'(seen), 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        set_ex(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        bus.mem_din = 8'h0;
        bus.mem_gnt = 1'b0;
        model_reset();

        @(negedge clk);
        compare_all();
        chk("reset_ready", 32'(bus.ex_ready), 32'd0);
        chk("reset_wb_data", bus.wb_data, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_release", 32'(bus.ex_ready), 32'd1);

        // Back-to-back pass ops
        set_ex(1'b1, 4'd0, 32'h0, 32'h0, 32'h12345678, 5'd5, 1'b1);
        tick();
        chk("pass1_wb_en", 32'(bus.wb_en), 32'd1);
        chk("pass1_wb_addr", 32'(bus.wb_addr), 32'd5);
        chk("pass1_wb_data", bus.wb_data, 32'h12345678);
        set_ex(1'b1, 4'd0, 32'h0, 32'h0, 32'h1, 5'd6, 1'b1);
        tick();
        chk("pass2_wb_en", 32'(bus.wb_en), 32'd1);
        chk("pass2_wb_addr", 32'(bus.wb_addr), 32'd6);
        chk("pass2_wb_data", bus.wb_data, 32'h1);
        chk("pass2_ready", 32'(bus.ex_ready), 32'd1);
        bus.ex_valid = 1'b0;
        tick();

        // LW at 0x100 with grant always high
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        set_ex(1'b1, 4'd3, 32'h100, 32'h0, 32'h0, 5'd9, 1'b1);
        bus.mem_gnt = 1'b1;
        tick();
        bus.ex_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                chk("lw_req", 32'(bus.mem_req), 32'd1);
                chk("lw_addr", bus.mem_addr, 32'h100 + 32'(c - 1));
                chk("lw_wr", 32'(bus.mem_wr), 32'd0);
            end
            if (c <= 5) chk("lw_busy", 32'(bus.ex_ready), 32'd0);
            if (c == 6) begin
                chk("lw_wb_en", 32'(bus.wb_en), 32'd1);
                chk("lw_wb_data", bus.wb_data, 32'h12345678);
                chk("lw_ready", 32'(bus.ex_ready), 32'd1);
            end
            if (c < 6) tick();
        end

        // Sign and zero extension
        poke(32'h300, 8'h80);
        poke(32'h310, 8'h01); poke(32'h311, 8'h80);
        do_load(4'd1, 32'h300, res, lat);
        chk("lb_data", res, 32'hFFFFFF80);
        chk("lb_latency", 32'(lat), 32'd3);
        do_load(4'd4, 32'h300, res, lat);
        chk("lbu_data", res, 32'h00000080);
        do_load(4'd2, 32'h310, res, lat);
        chk("lh_data", res, 32'hFFFF8001);
        do_load(4'd5, 32'h310, res, lat);
        chk("lhu_data", res, 32'h00008001);

        // SH with grant withheld for two cycles
        set_ex(1'b1, 4'd7, 32'h200, 32'hAABBCCDD, 32'h0, 5'd4, 1'b1);
        tick();
        bus.ex_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 3) begin
                chk("sh_addr0", bus.mem_addr, 32'h200);
                chk("sh_dout0", 32'(bus.mem_dout), 32'hDD);
                chk("sh_wr0", 32'(bus.mem_wr), 32'd1);
            end
            if (c == 4) begin
                chk("sh_addr1", bus.mem_addr, 32'h201);
                chk("sh_dout1", 32'(bus.mem_dout), 32'hCC);
            end
            if (c == 5) chk("sh_ready", 32'(bus.ex_ready), 32'd1);
            chk("sh_no_wb", 32'(bus.wb_en), 32'd0);
            bus.mem_gnt = (c >= 3);
            if (c < 5) tick();
        end
        chk("sh_mem0", 32'(rd_phys(32'h200)), 32'hDD);
        chk("sh_mem1", 32'(rd_phys(32'h201)), 32'hCC);

        // LW wrapping past the top of the address space
        bus.mem_gnt = 1'b1;
        set_ex(1'b1, 4'd3, 32'hFFFFFFFE, 32'h0, 32'h0, 5'd2, 1'b1);
        tick();
        bus.ex_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("wrap_addr", bus.mem_addr, 32'hFFFFFFFE + 32'(c - 1));
            tick();
        end
        tick();
        chk("wrap_wb_en", 32'(bus.wb_en), 32'd1);

        // Reset in the middle of an LW
        set_ex(1'b1, 4'd3, 32'h400, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        bus.ex_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_req_drop", 32'(bus.mem_req), 32'd0);
        chk("rst_ready", 32'(bus.ex_ready), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(bus.ex_ready), 32'd1);
        set_ex(1'b1, 4'd0, 32'h0, 32'h0, 32'h7, 5'd3, 1'b1);
        tick();
        bus.ex_valid = 1'b0;
        chk("post_rst_wb_en", 32'(bus.wb_en), 32'd1);
        chk("post_rst_wb_addr", 32'(bus.wb_addr), 32'd3);
        chk("post_rst_wb_data", bus.wb_data, 32'h7);
        tick();

        // Randomized traffic with occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            set_ex($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                               : 32'($urandom_range(0, 63)),
                   $urandom, $urandom, 5'($urandom), $urandom_range(0, 3) != 0);
            bus.mem_gnt = $urandom_range(0, 3) != 0;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 249) == 0) rst = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
